// File: rtl/alu_arb_pkg.sv
// Shared request type, opcode aliases and the op-legality check for the ALU arbiter.
`include "defines.sv"
package alu_arb_pkg;
    localparam int TAG_W_DEF = 4;

    localparam logic [3:0] OP_ADD  = `EXE_ADD_OP;
    localparam logic [3:0] OP_SUB  = `EXE_SUB_OP;
    localparam logic [3:0] OP_SLL  = `EXE_SLL_OP;
    localparam logic [3:0] OP_SLT  = `EXE_SLT_OP;
    localparam logic [3:0] OP_SLTU = `EXE_SLTU_OP;
    localparam logic [3:0] OP_XOR  = `EXE_XOR_OP;
    localparam logic [3:0] OP_SRL  = `EXE_SRL_OP;
    localparam logic [3:0] OP_SRA  = `EXE_SRA_OP;
    localparam logic [3:0] OP_OR   = `EXE_OR_OP;
    localparam logic [3:0] OP_AND  = `EXE_AND_OP;

    typedef struct packed {
        logic [31:0]          a;
        logic [31:0]          b;
        logic [3:0]           op;
        logic [TAG_W_DEF-1:0] tag;
    } req_t;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
            OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/alu.sv
// Core 32-bit ALU: purely combinational, shift amount taken from b[24:20].
`include "defines.sv"
module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] y
);
    logic [4:0] shamt;
    assign shamt = b[24:20];

    always_comb begin
        // NOTE: default assignment first so every path drives y and no latch is inferred.
        y = '0;
        case (op)
            `EXE_ADD_OP:  y = a + b;
            `EXE_SUB_OP:  y = a - b;
            `EXE_SLL_OP:  y = a << shamt;
            `EXE_SLT_OP:  y = {31'b0, $signed(a) < $signed(b)};
            `EXE_SLTU_OP: y = {31'b0, a < b};
            `EXE_XOR_OP:  y = a ^ b;
            `EXE_SRL_OP:  y = a >> shamt;
            `EXE_SRA_OP:  y = $unsigned($signed(a) >>> shamt);
            `EXE_OR_OP:   y = a | b;
            `EXE_AND_OP:  y = a & b;
            default:      y = '0;
        endcase
    end
endmodule

// File: rtl/defines.sv
// Opcode constants for the core ALU. The ten defined operations occupy codes 0-9;
// codes 10-15 are undefined.
`ifndef DEFINES_SV
`define DEFINES_SV
`define EXE_ADD_OP  4'd0
`define EXE_SUB_OP  4'd1
`define EXE_SLL_OP  4'd2
`define EXE_SLT_OP  4'd3
`define EXE_SLTU_OP 4'd4
`define EXE_XOR_OP  4'd5
`define EXE_SRL_OP  4'd6
`define EXE_SRA_OP  4'd7
`define EXE_OR_OP   4'd8
`define EXE_AND_OP  4'd9
`endif

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU behind a round-robin grant and a single result register.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [3:0]       req0_op,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [3:0]       req1_op,
    input  logic [TAG_W-1:0] req1_tag,
    input  logic             flush,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_y,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err
);
    logic        last_grant;
    logic        grant0, grant1;
    logic        can_accept;
    logic        xfer;
    req_t        sel;
    logic [31:0] alu_y;

    // last_grant == 1 means requester 1 won most recently, so requester 0 wins a tie.
    assign grant0     = req0_valid && (!req1_valid || last_grant);
    assign grant1     = req1_valid && (!req0_valid || !last_grant);
    assign can_accept = !reset && !flush && (!rsp_valid || rsp_ready);
    assign req0_ready = can_accept && grant0;
    assign req1_ready = can_accept && grant1;
    assign xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign sel = grant1 ? '{a: req1_a, b: req1_b, op: req1_op, tag: req1_tag}
                        : '{a: req0_a, b: req0_b, op: req0_op, tag: req0_tag};

    alu u_alu (
        .a  (sel.a),
        .b  (sel.b),
        .op (sel.op),
        .y  (alu_y)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
        if (reset) begin
            rsp_valid  <= 1'b0;
            rsp_y      <= '0;
            rsp_id     <= 1'b0;
            rsp_tag    <= '0;
            rsp_err    <= 1'b0;
            last_grant <= 1'b1;
        end else if (flush) begin
            rsp_valid <= 1'b0;
        end else if (xfer) begin
            rsp_valid  <= 1'b1;
            rsp_y      <= op_legal(sel.op) ? alu_y : '0;
            rsp_err    <= !op_legal(sel.op);
            rsp_id     <= grant1;
            rsp_tag    <= sel.tag;
            last_grant <= grant1;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: TAG_W, 4, width of the requester-supplied transaction tag.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req0_valid / req1_valid  input  1  requester i presents an operation.
REQ-005 Port: req0_ready / req1_ready  output  1  arbiter accepts requester i this cycle.
REQ-006 Port: req0_a, req0_b / req1_a, req1_b  input  32  operands, same semantics as the core ALU a/b (shift amount taken from b[24:20]).
REQ-007 Port: req0_op / req1_op  input  4  operation code, one of the ten EXE_*_OP codes in defines.sv.
REQ-008 Port: req0_tag / req1_tag  input  TAG_W  opaque tag returned with the result.
REQ-009 Port: flush  input  1  discard the pending result, block acceptance this cycle.
REQ-010 Port: rsp_valid  output  1  result register holds a result.
REQ-011 Port: rsp_ready  input  1  consumer takes the result.
REQ-012 Port: rsp_y  output  32  result; rsp_id  output  1  winning requester index; rsp_tag  output  TAG_W  its tag; rsp_err  output  1  undefined op.

Function
REQ-013 Shall share one ALU instance between two requesters, with a single output register stage.
REQ-014 can_accept = !flush && (!rsp_valid || rsp_ready); reqi_ready = can_accept && grant_i.
REQ-015 Grant: only one requester valid -> it wins; both valid -> the index not equal to last_grant wins; none valid -> no grant.
REQ-016 Transfer on reqi_valid && reqi_ready; last_grant updates to i only on a transfer.
REQ-017 reqi_ready may depend on either valid; a requester shall not retract valid nor change payload while valid && !ready (bench assertion).
REQ-018 Latency: request transferred in cycle N -> rsp_valid=1 with its result in cycle N+1; throughput one result per cycle while rsp_ready=1.
REQ-019 While rsp_valid && !rsp_ready && !flush, rsp_y/rsp_id/rsp_tag/rsp_err shall hold stable and both readies are 0.
REQ-020 Drain-and-refill in the same cycle (rsp_ready=1 plus a transfer) shall load the new result with no bubble.
REQ-021 rsp_valid clears when rsp_ready=1 and no transfer occurs.
REQ-022 Undefined op: rsp_y=0, rsp_err=1; otherwise rsp_err=0 and rsp_y equals the ALU result bit-exactly (32-bit wrap, SLT signed, SLTU unsigned, SRA sign-filling).
REQ-023 flush=1: rsp_valid=0 next cycle, no transfer this cycle, last_grant unchanged; flush overrides rsp_ready.

Reset
REQ-024 Reset (flush-equivalent, higher priority) gives next cycle: rsp_valid=0, rsp_y=0, rsp_id=0, rsp_tag=0, rsp_err=0, last_grant=1 (requester 0 wins the first tie).
REQ-025 While reset=1 both readies shall be 0; a result pending at reset is discarded, never delivered.

Structure
REQ-026 Opcode constants stay in defines.sv; a shared package alu_arb_pkg holds the request struct typedef (a, b, op, tag) and the op-legality function.
REQ-027 The existing alu module shall be instantiated once as the only sub-module, between the grant mux and the result register.

Verification
REQ-028 After reset, req0 ADD a=5 b=7 tag=3, rsp_ready=1 -> next cycle rsp_valid=1, rsp_y=12, rsp_id=0, rsp_tag=3, rsp_err=0.
REQ-029 Both valid for 4 cycles, rsp_ready=1, req1 SUB a=3 b=5 -> grants 0,1,0,1; req1 results 0xFFFFFFFE.
REQ-030 rsp_ready=0 for 3 cycles with rsp_valid=1 and both requesters valid -> readies 0, rsp outputs stable; rsp_ready=1 -> next transfer same cycle, new result next cycle.
REQ-031 SRA a=0x80000000 b=0x00400000 -> 0xF8000000; SLT a=0xFFFFFFFF b=1 -> 1; SLTU same operands -> 0.
REQ-032 Undefined op code, tag=7 -> rsp_err=1, rsp_y=0, rsp_tag=7.
REQ-033 flush (then separately reset) asserted with a result pending and req0 valid -> rsp_valid=0 next cycle, no acceptance that cycle, last_grant unchanged by flush and 1 after reset.
